// File: rtl/euler_step_ctrl_if.sv
// Handshake bundle between the Euler step controller and its operand pipes, multiplier and result RAM.
interface euler_step_ctrl_if #(
    parameter int unsigned ADD_SIZE = 16
);
    logic                start;
    logic                clear;
    logic [ADD_SIZE-1:0] step_count;
    logic [ADD_SIZE-1:0] base_addr;
    logic                data_ready1;
    logic                data_ready2;
    logic                add_ovf;
    logic                mul_done;
    logic                mul_ovf;
    logic                ack1;
    logic                ack2;
    logic                mul_start;
    logic                wr_en;
    logic [ADD_SIZE-1:0] wr_addr;
    logic                busy;
    logic                finished;
    logic                overflow_flag;
    logic [ADD_SIZE-1:0] steps_done;

    // Controller side: consumes requests and status, issues pulses and RAM strobes.
    modport master (
        input  start, clear, step_count, base_addr,
        input  data_ready1, data_ready2, add_ovf, mul_done, mul_ovf,
        output ack1, ack2, mul_start, wr_en, wr_addr,
        output busy, finished, overflow_flag, steps_done
    );

    // Environment side: pipes, multiplier, RAM and the run requester.
    modport slave (
        output start, clear, step_count, base_addr,
        output data_ready1, data_ready2, add_ovf, mul_done, mul_ovf,
        input  ack1, ack2, mul_start, wr_en, wr_addr,
        input  busy, finished, overflow_flag, steps_done
    );
endinterface

// File: rtl/euler_step_ctrl.sv
// Sequences N Euler steps: wait for both operands, launch the multiplier, write the result,
// and trap adder/multiplier overflow or multiplier timeout in a sticky error state.
module euler_step_ctrl #(
    parameter int unsigned ADD_SIZE    = 16,
    parameter int unsigned DATA_SIZE   = 16,
    parameter int unsigned MUL_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    euler_step_ctrl_if.master bus
);

    localparam int unsigned TMO_W = $clog2(MUL_TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_OPS = 3'd1;
    localparam logic [2:0] ST_MUL      = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ERR      = 3'd5;

    // Parameter sanity; DATA_SIZE only describes the surrounding datapath.
    if (ADD_SIZE == 0) begin : g_bad_add_size
        $error("euler_step_ctrl: ADD_SIZE must be nonzero");
    end
    if (DATA_SIZE == 0) begin : g_bad_data_size
        $error("euler_step_ctrl: DATA_SIZE must be nonzero");
    end
    if (MUL_TIMEOUT == 0) begin : g_bad_timeout
        $error("euler_step_ctrl: MUL_TIMEOUT must be nonzero");
    end

    logic [2:0]          state_q,  state_nxt;
    logic [ADD_SIZE-1:0] n_q,      n_nxt;
    logic [ADD_SIZE-1:0] addr_q,   addr_nxt;
    logic [ADD_SIZE-1:0] steps_q,  steps_nxt;
    logic [TMO_W-1:0]    tmo_q,    tmo_nxt;
    logic                ovf_q,    ovf_nxt;
    logic                busy_q,   busy_nxt;
    logic                fin_q,    fin_nxt;
    logic                pulse_q,  pulse_nxt;
    logic                wr_en_q,  wr_en_nxt;
    logic [ADD_SIZE-1:0] steps_inc;

    assign steps_inc = steps_q + ADD_SIZE'(1);

    // Next state plus next values of every registered output.
    always_comb begin
        state_nxt = state_q;
        n_nxt     = n_q;
        addr_nxt  = addr_q;
        steps_nxt = steps_q;
        ovf_nxt   = ovf_q;

        if (bus.clear) begin
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
            steps_nxt = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        n_nxt     = bus.step_count;
                        addr_nxt  = bus.base_addr;
                        steps_nxt = '0;
                        state_nxt = (bus.step_count == '0) ? ST_DONE : ST_WAIT_OPS;
                    end
                end
                ST_WAIT_OPS: begin
                    if (bus.data_ready1 && bus.data_ready2) begin
                        state_nxt = bus.add_ovf ? ST_ERR : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (bus.mul_done) begin
                        state_nxt = bus.mul_ovf ? ST_ERR : ST_WRITE;
                    end else if (tmo_q == TMO_W'(MUL_TIMEOUT - 1)) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_WRITE: begin
                    addr_nxt  = addr_q + ADD_SIZE'(1);
                    steps_nxt = steps_inc;
                    state_nxt = (steps_inc == n_q) ? ST_DONE : ST_WAIT_OPS;
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                ST_ERR: begin
                    state_nxt = ST_ERR;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        if (state_nxt == ST_ERR) begin
            ovf_nxt = 1'b1;
        end

        // Counts cycles already spent in MUL; any fresh entry starts again from zero.
        tmo_nxt   = ((state_q == ST_MUL) && (state_nxt == ST_MUL)) ? (tmo_q + TMO_W'(1)) : '0;
        pulse_nxt = (state_nxt == ST_MUL) && (state_q != ST_MUL);
        wr_en_nxt = (state_nxt == ST_WRITE);
        fin_nxt   = (state_nxt == ST_DONE);
        busy_nxt  = (state_nxt == ST_WAIT_OPS) || (state_nxt == ST_MUL) ||
                    (state_nxt == ST_WRITE)    || (state_nxt == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            addr_q  <= '0;
            steps_q <= '0;
            tmo_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            pulse_q <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            n_q     <= n_nxt;
            addr_q  <= addr_nxt;
            steps_q <= steps_nxt;
            tmo_q   <= tmo_nxt;
            ovf_q   <= ovf_nxt;
            busy_q  <= busy_nxt;
            fin_q   <= fin_nxt;
            pulse_q <= pulse_nxt;
            wr_en_q <= wr_en_nxt;
        end
    end

    // One launch flop drives both operand acks and the multiplier start.
    assign bus.ack1          = pulse_q;
    assign bus.ack2          = pulse_q;
    assign bus.mul_start     = pulse_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = addr_q;
    assign bus.busy          = busy_q;
    assign bus.finished      = fin_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.steps_done    = steps_q;

endmodule
